// File: rtl/vending_machine.sv
// Single-product vending controller: price 15, accepts 5/10 coins, registered
// dispense pulse and change outputs one cycle after the completing coin.
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  output logic       out,
  output logic [1:0] change
);

  localparam int unsigned COIN_W = 2;

  localparam logic [COIN_W-1:0] COIN_5   = COIN_W'(2'b01);
  localparam logic [COIN_W-1:0] COIN_10  = COIN_W'(2'b10);
  localparam logic [COIN_W-1:0] CHG_NONE = COIN_W'(2'b00);
  localparam logic [COIN_W-1:0] CHG_5    = COIN_W'(2'b01);

  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              out_q, out_d;
  logic [COIN_W-1:0] change_q, change_d;

  // State and output registers; reset discards any credit without refund.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S0;
      out_q    <= 1'b0;
      change_q <= CHG_NONE;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      change_q <= change_d;
    end
  end

  // Credit accumulation; no-coin and the invalid code both hold the credit.
  always_comb begin
    state_d  = state_q;
    out_d    = 1'b0;
    change_d = CHG_NONE;
    case (state_q)
      S0: begin
        if (in == COIN_5) begin
          state_d = S5;
        end else if (in == COIN_10) begin
          state_d = S10;
        end
      end
      S5: begin
        if (in == COIN_5) begin
          state_d = S10;
        end else if (in == COIN_10) begin
          state_d = S0;
          out_d   = 1'b1;
        end
      end
      S10: begin
        if (in == COIN_5) begin
          state_d = S0;
          out_d   = 1'b1;
        end else if (in == COIN_10) begin
          state_d  = S0;
          out_d    = 1'b1;
          change_d = CHG_5;
        end
      end
      default: state_d = S0;
    endcase
  end

  assign out    = out_q;
  assign change = change_q;

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: a credit-arithmetic model predicts each
// cycle's out/change, and a negedge monitor checks the DUT against the queue.
module tb_vending_machine;

  typedef struct packed {
    logic       out;
    logic [1:0] change;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] in  = 2'b00;
  logic       out;
  logic [1:0] change;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   credit = 0;
  int   step_id = 0;

  vending_machine dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .out    (out),
    .change (change)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at negedge, then update the model after the edge.
  task automatic apply(input logic r, input logic [1:0] coin);
    exp_t e;
    int   value;
    @(negedge clk);
    rst = r;
    in  = coin;
    @(posedge clk);
    e.out    = 1'b0;
    e.change = 2'b00;
    e.id     = step_id;
    step_id++;
    if (r) begin
      credit = 0;
    end else begin
      value = (coin == 2'b01) ? 5 : (coin == 2'b10) ? 10 : 0;
      credit += value;
      if (credit >= 15) begin
        e.out    = 1'b1;
        e.change = 2'(((credit - 15) / 5));
        credit   = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per clocked step, checked at the following negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (out !== e.out || change !== e.change) begin
          bad++;
          $display("FAIL step%0d out/change: got %b/%b expected %b/%b",
                   e.id, out, change, e.out, e.change);
        end
      end
    end
  end

  initial begin
    logic [1:0] coin;
    logic       r;
    int         guard;

    // Reset, then 5 held for four edges: vend on the third coin.
    apply(1'b1, 2'b00);
    repeat (4) apply(1'b0, 2'b01);
    apply(1'b1, 2'b00);
    // 10 then 5.
    apply(1'b0, 2'b10); apply(1'b0, 2'b01); apply(1'b0, 2'b00);
    // 10 then 10: change of 5, out drops next cycle.
    apply(1'b0, 2'b10); apply(1'b0, 2'b10); apply(1'b0, 2'b00);
    // 5 then 10, then idle three cycles.
    apply(1'b0, 2'b01); apply(1'b0, 2'b10);
    repeat (3) apply(1'b0, 2'b00);
    // 5, idle/invalid cycles hold credit, then 10 vends.
    apply(1'b0, 2'b01);
    apply(1'b0, 2'b00); apply(1'b0, 2'b11); apply(1'b0, 2'b11); apply(1'b0, 2'b00);
    apply(1'b0, 2'b10);
    apply(1'b0, 2'b00);
    // 10, then reset with a simultaneous 5; a later 5 must not vend.
    apply(1'b0, 2'b10); apply(1'b1, 2'b01);
    apply(1'b0, 2'b01); apply(1'b0, 2'b00);
    // Completing the purchase from S5 proves the reset cleared the 10.
    apply(1'b0, 2'b10); apply(1'b0, 2'b00);

    // Randomized coins with occasional reset.
    for (int i = 0; i < 600; i++) begin
      coin = 2'($urandom_range(0, 3));
      r    = ($urandom_range(0, 24) == 0);
      apply(r, coin);
    end
    apply(1'b0, 2'b00);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
